aes_spi_slave_if: RTL

SPI slave front end for the AES core, sitting directly downstream of the SPI master that drives key/data traffic.
- Deserialises a load frame (header, 128-bit data block, 128/192/256-bit key) and launches the encrypt/decrypt core with a one-cycle start pulse.
- Captures the core result and serialises it back on MISO during a readback frame.
- All SPI inputs are oversampled in the system clock domain.

---
 rtl/aes_spi_slave_if.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_spi_slave_if.sv
// SPI mode-0 slave front end for the AES core: deserialises load frames, launches the
// core with a one-cycle pulse, and shifts the captured result back out on readback frames.
module aes_spi_slave_if #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_W      = 128,
   parameter int KEY_W_MAX   = 256
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 spi_sclk,
   input  logic                 spi_cs_n,
   input  logic                 spi_mosi,
   output logic                 spi_miso,
   output logic                 core_start,
   output logic                 core_decrypt,
   output logic [1:0]           core_nk,
   output logic [DATA_W-1:0]    core_data,
   output logic [KEY_W_MAX-1:0] core_key,
   input  logic                 core_done,
   input  logic [DATA_W-1:0]    core_result,
   output logic                 busy,
   output logic                 result_valid,
   output logic                 frame_err
);
   localparam int CNT_W  = $clog2(DATA_W + KEY_W_MAX + 1);
   localparam int KIDX_W = $clog2(KEY_W_MAX);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_RX, S_LAUNCH, S_BUSY, S_TX, S_DISCARD
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   cs_prev_q, cs_prev_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]             hdr_q, hdr_d;
   logic                   op_q, op_d;
   logic [1:0]             nk_q, nk_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic [KEY_W_MAX-1:0]   key_q, key_d;
   logic [DATA_W-1:0]      result_q, result_d;
   logic [DATA_W-1:0]      tx_q, tx_d;
   logic                   result_valid_q, result_valid_d;
   logic                   miso_q, miso_d;
   logic                   frame_err_q, frame_err_d;

   logic              sclk_s, cs_s, mosi_s;
   logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic [7:0]        hdr_next;
   logic [CNT_W-1:0]  exp_len;
   logic [KIDX_W-1:0] key_idx;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_s;
   assign sclk_fall = ~sclk_s & sclk_prev_q & ~cs_s;
   assign cs_fall   = ~cs_s & cs_prev_q;
   assign cs_rise   = cs_s & ~cs_prev_q;
   assign hdr_next  = {hdr_q[6:0], mosi_s};
   // Key bits fill from the top of core_key down, so short keys stay left-aligned.
   assign key_idx   = KIDX_W'(CNT_W'(DATA_W + KEY_W_MAX - 1) - bit_cnt_q);

   always_comb begin
      case (nk_q)
         2'b00:   exp_len = CNT_W'(DATA_W + 128);
         2'b01:   exp_len = CNT_W'(DATA_W + 192);
         default: exp_len = CNT_W'(DATA_W + 256);
      endcase
   end

   always_comb begin
      // NOTE: every _d gets its hold value first, so no path through the case leaves a latch.
      sclk_sync_d    = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_d      = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_d    = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_d    = sclk_s;
      cs_prev_d      = cs_s;
      state_d        = state_q;
      bit_cnt_d      = bit_cnt_q;
      hdr_d          = hdr_q;
      op_d           = op_q;
      nk_d           = nk_q;
      data_d         = data_q;
      key_d          = key_q;
      result_d       = result_q;
      tx_d           = tx_q;
      result_valid_d = result_valid_q;
      miso_d         = miso_q;
      frame_err_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cs_fall) begin
               state_d   = S_HDR;
               bit_cnt_d = '0;
            end
         end
         S_HDR: begin
            if (cs_rise) begin
               state_d     = S_IDLE;
               frame_err_d = 1'b1;
            end else if (sclk_rise) begin
               hdr_d     = hdr_next;
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == CNT_W'(7)) begin
                  bit_cnt_d = '0;
                  if (hdr_next[6]) begin
                     state_d = S_TX;
                     tx_d    = result_valid_q ? result_q : '0;
                     miso_d  = 1'b0;
                  end else if (hdr_next[1:0] == 2'b11) begin
                     state_d     = S_DISCARD;
                     frame_err_d = 1'b1;
                  end else begin
                     state_d = S_RX;
                     op_d    = hdr_next[7];
                     nk_d    = hdr_next[1:0];
                     key_d   = '0;
                  end
               end
            end
         end
         S_RX: begin
            if (cs_rise) begin
               if (bit_cnt_q == exp_len) begin
                  state_d = S_LAUNCH;
               end else begin
                  state_d     = S_IDLE;
                  frame_err_d = 1'b1;
               end
            end else if (sclk_rise) begin
               if (bit_cnt_q == exp_len) begin
                  state_d     = S_DISCARD;
                  frame_err_d = 1'b1;
               end else begin
                  if (bit_cnt_q < CNT_W'(DATA_W)) begin
                     data_d = {data_q[DATA_W-2:0], mosi_s};
                  end else begin
                     key_d[key_idx] = mosi_s;
                  end
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_LAUNCH: begin
            result_valid_d = 1'b0;
            state_d        = S_BUSY;
         end
         S_BUSY: begin
            // A new frame during BUSY is dropped whole; only its start is flagged.
            if (cs_fall) begin
               frame_err_d = 1'b1;
            end
            if (core_done) begin
               result_d       = core_result;
               result_valid_d = 1'b1;
               state_d        = S_IDLE;
            end
         end
         S_TX: begin
            if (cs_rise) begin
               state_d = S_IDLE;
            end else if (sclk_fall) begin
               miso_d = tx_q[DATA_W-1];
               tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end
         end
         S_DISCARD: begin
            if (cs_rise) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the wide data/key/result registers are cleared too; the core must never see stale key material after reset.
         state_q        <= S_IDLE;
         sclk_sync_q    <= '0;
         cs_sync_q      <= '0;
         mosi_sync_q    <= '0;
         sclk_prev_q    <= 1'b0;
         cs_prev_q      <= 1'b0;
         bit_cnt_q      <= '0;
         hdr_q          <= '0;
         op_q           <= 1'b0;
         nk_q           <= '0;
         data_q         <= '0;
         key_q          <= '0;
         result_q       <= '0;
         tx_q           <= '0;
         result_valid_q <= 1'b0;
         miso_q         <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking updates keep every flop sampling pre-edge values regardless of statement order.
         state_q        <= state_d;
         sclk_sync_q    <= sclk_sync_d;
         cs_sync_q      <= cs_sync_d;
         mosi_sync_q    <= mosi_sync_d;
         sclk_prev_q    <= sclk_prev_d;
         cs_prev_q      <= cs_prev_d;
         bit_cnt_q      <= bit_cnt_d;
         hdr_q          <= hdr_d;
         op_q           <= op_d;
         nk_q           <= nk_d;
         data_q         <= data_d;
         key_q          <= key_d;
         result_q       <= result_d;
         tx_q           <= tx_d;
         result_valid_q <= result_valid_d;
         miso_q         <= miso_d;
         frame_err_q    <= frame_err_d;
      end
   end

   assign spi_miso     = (state_q == S_TX) & miso_q;
   assign core_start   = (state_q == S_LAUNCH);
   assign busy         = (state_q == S_LAUNCH) || (state_q == S_BUSY);
   assign core_decrypt = op_q;
   assign core_nk      = nk_q;
   assign core_data    = data_q;
   assign core_key     = key_q;
   assign result_valid = result_valid_q;
   assign frame_err    = frame_err_q;

endmodule
